// File: rtl/axi_w_burst_router.sv
// axi_w_burst_router
//   W-channel router for one target port of the AXI node. The AW side queues one
//   entry {dest, err, len} per accepted write burst. The head entry becomes the
//   active burst. Its W beats are steered to the one-hot destination initiator
//   port, or they are sunk locally when the burst is a decode error. Each burst's
//   beat count is checked against AWLEN. The next queued burst starts on the same
//   edge that retires the current one, so back-to-back bursts have no bubble.
// Ports
//   clk, rst        clock; synchronous active-high reset
//   push_*          burst entry push (valid/ready, dest, err, len)
//   wvalid_i/wlast_i/wready_o   slave-side W handshake
//   wvalid_o/wlast_o/wready_i   initiator-side W handshake (one valid/ready per port)
//   err_done_o      pulse when the last beat of a sunk burst is accepted
//   len_err_o       pulse when a beat-count / AWLEN mismatch is seen
//   fifo_count_o    queued entries, not counting the active burst
module axi_w_burst_router #(
   parameter int N_INIT_PORT = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int LEN_W       = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push_valid_i,
   output logic                             push_ready_o,
   input  logic [N_INIT_PORT-1:0]           push_dest_i,
   input  logic                             push_err_i,
   input  logic [LEN_W-1:0]                 push_len_i,
   input  logic                             wvalid_i,
   input  logic                             wlast_i,
   output logic                             wready_o,
   output logic [N_INIT_PORT-1:0]           wvalid_o,
   output logic                             wlast_o,
   input  logic [N_INIT_PORT-1:0]           wready_i,
   output logic                             err_done_o,
   output logic                             len_err_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH+1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FWD, S_SINK} state_t;

   // entry storage (data only, no reset needed)
   logic [N_INIT_PORT-1:0] r_mem_dest [FIFO_DEPTH];
   logic                   r_mem_err  [FIFO_DEPTH];
   logic [LEN_W-1:0]       r_mem_len  [FIFO_DEPTH];

   logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]       r_count;

   state_t                 r_state, w_state_nxt;
   logic [N_INIT_PORT-1:0] r_act_dest;
   logic [LEN_W-1:0]       r_act_len;
   logic [LEN_W-1:0]       r_cnt;
   logic                   r_over;      // overrun already reported for this burst

   logic w_full, w_fifo_ne, w_push, w_bad_dest;
   logic w_accept, w_end, w_load, w_overrun;

   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_fifo_ne = (r_count != '0);
   assign w_push    = push_valid_i & ~w_full;   // full refuses even if a pop happens this cycle
   // zero or multi-hot destination cannot be routed: treat as decode error
   assign w_bad_dest = (push_dest_i == '0) ||
                       ((push_dest_i & (push_dest_i - N_INIT_PORT'(1))) != '0);

   always_comb begin
      w_state_nxt = r_state;
      wready_o    = 1'b0;
      wvalid_o    = '0;
      wlast_o     = 1'b0;
      case (r_state)
         S_FWD: begin
            // ready reflects only the selected port, independent of wvalid_i
            wready_o = |(wready_i & r_act_dest);
            wvalid_o = {N_INIT_PORT{wvalid_i}} & r_act_dest;
            wlast_o  = wlast_i;
         end
         S_SINK: wready_o = 1'b1;
         default: ;
      endcase
      w_accept = wvalid_i & wready_o;           // wready_o is 0 in IDLE
      w_end    = w_accept & wlast_i;
      // load from IDLE (one bubble) or straight off a burst end (no bubble)
      w_load   = ((r_state == S_IDLE) || w_end) && w_fifo_ne;
      if (w_load)
         w_state_nxt = r_mem_err[r_rd_ptr] ? S_SINK : S_FWD;
      else if (w_end)
         w_state_nxt = S_IDLE;
      w_overrun  = w_accept & ~wlast_i & (r_cnt == r_act_len) & ~r_over;
      len_err_o  = (w_end && (r_cnt != r_act_len)) || w_overrun;
      err_done_o = w_end && (r_state == S_SINK);
   end

   assign push_ready_o = ~w_full;
   assign fifo_count_o = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_dest[r_wr_ptr] <= push_dest_i;
         r_mem_err[r_wr_ptr]  <= push_err_i | w_bad_dest;
         r_mem_len[r_wr_ptr]  <= push_len_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_state    <= S_IDLE;
         r_act_dest <= '0;
         r_act_len  <= '0;
         r_cnt      <= '0;
         r_over     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_load) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_load})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: ;
         endcase
         if (w_load) begin
            r_act_dest <= r_mem_dest[r_rd_ptr];
            r_act_len  <= r_mem_len[r_rd_ptr];
            r_cnt      <= '0;
            r_over     <= 1'b0;
         end else if (w_end) begin
            r_cnt      <= '0;
            r_over     <= 1'b0;
         end else if (w_accept) begin
            if (r_cnt != '1) r_cnt <= r_cnt + LEN_W'(1);   // saturate
            if (w_overrun)   r_over <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_w_burst_router.sv
// Randomized bench for axi_w_burst_router against a queue-based burst model.
module tb_axi_w_burst_router;

   logic       clk = 1'b0;
   logic       rst;
   logic       push_valid_i, push_ready_o, push_err_i;
   logic [3:0] push_dest_i;
   logic [7:0] push_len_i;
   logic       wvalid_i, wlast_i, wready_o, wlast_o, err_done_o, len_err_o;
   logic [3:0] wvalid_o, wready_i;
   logic [3:0] fifo_count_o;

   axi_w_burst_router #(.N_INIT_PORT(4), .FIFO_DEPTH(8), .LEN_W(8)) dut (
      .clk(clk), .rst(rst),
      .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
      .push_dest_i(push_dest_i), .push_err_i(push_err_i), .push_len_i(push_len_i),
      .wvalid_i(wvalid_i), .wlast_i(wlast_i), .wready_o(wready_o),
      .wvalid_o(wvalid_o), .wlast_o(wlast_o), .wready_i(wready_i),
      .err_done_o(err_done_o), .len_err_o(len_err_o), .fifo_count_o(fifo_count_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: list of pending bursts plus the one being transferred
   typedef struct {
      logic [3:0] dest;
      bit         err;
      int         len;
   } ent_t;

   ent_t q[$];
   ent_t act;
   ent_t ne;
   bit   act_on = 0;
   int   beats  = 0;
   bit   over_rep = 0;

   // phase knobs: push %, wvalid %, per-port wready %, bad dest %, reset %
   int ph_pv [6] = '{40, 90, 30, 60, 50, 40};
   int ph_wv [6] = '{60,  0, 95, 80, 70, 70};
   int ph_wr [6] = '{70, 50, 100, 60, 80, 70};
   int ph_bad[6] = '{10, 10,  5, 20, 10, 10};
   int ph_rst[6] = '{ 0,  0,  0,  1,  0,  2};

   initial begin
      logic [3:0] e_wvalid;
      logic       e_wready, e_wlast, e_lenerr, e_errd;
      bit         acc, fin, take;
      int         bs, n;

      rst = 1'b1;
      push_valid_i = 0; push_dest_i = 0; push_err_i = 0; push_len_i = 0;
      wvalid_i = 0; wlast_i = 0; wready_i = 0;
      repeat (2) @(posedge clk);

      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 400; c++) begin
            #1;
            // first cycle stays in reset with W activity to check the idle outputs
            rst          = (p == 0 && c == 0) ? 1'b1 : ($urandom_range(0, 99) < ph_rst[p]);
            push_valid_i = ($urandom_range(0, 99) < ph_pv[p]);
            push_dest_i  = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 99) < ph_bad[p])
               push_dest_i = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'(push_dest_i | 4'(1 << $urandom_range(0, 3)) | 4'b0001);
            push_err_i   = ($urandom_range(0, 99) < 8);
            push_len_i   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 12)) : 8'($urandom_range(0, 3));
            wvalid_i     = (p == 0 && c == 0) ? 1'b1 : ($urandom_range(0, 99) < ph_wv[p]);
            for (int k = 0; k < 4; k++) wready_i[k] = ($urandom_range(0, 99) < ph_wr[p]);
            if (act_on && beats <= act.len) begin
               wlast_i = (beats == act.len);
               if ($urandom_range(0, 9) == 0) wlast_i = ~wlast_i;
            end else begin
               wlast_i = $urandom_range(0, 1);
            end

            #1;
            // expected outputs for the current model state and inputs
            e_wready = 0; e_wvalid = 0; e_wlast = 0;
            if (act_on) begin
               if (act.err) e_wready = 1;
               else begin
                  e_wready = |(wready_i & act.dest);
                  e_wvalid = wvalid_i ? act.dest : 4'h0;
                  e_wlast  = wlast_i;
               end
            end
            acc = act_on && wvalid_i && e_wready;
            fin = acc && wlast_i;
            bs  = (beats > 255) ? 255 : beats;
            e_lenerr = (fin && bs != act.len) || (acc && !wlast_i && bs == act.len && !over_rep);
            e_errd   = fin && act.err;

            chk("push_ready", 32'(push_ready_o), 32'(q.size() < 8));
            chk("fifo_count", 32'(fifo_count_o), 32'(q.size()));
            chk("wready",     32'(wready_o),     32'(e_wready));
            chk("wvalid",     32'(wvalid_o),     32'(e_wvalid));
            chk("wlast",      32'(wlast_o),      32'(e_wlast));
            chk("len_err",    32'(len_err_o),    32'(e_lenerr));
            chk("err_done",   32'(err_done_o),   32'(e_errd));

            // advance the model across the coming edge
            if (rst) begin
               q.delete();
               act_on = 0; beats = 0; over_rep = 0;
            end else begin
               n    = q.size();
               take = (n > 0) && (!act_on || fin);
               if (acc && !fin) begin
                  if (bs == act.len) over_rep = 1;
                  beats++;
               end
               if (take) begin
                  act = q.pop_front();
                  act_on = 1; beats = 0; over_rep = 0;
               end else if (fin) begin
                  act_on = 0;
               end
               if (push_valid_i && n < 8) begin
                  ne.dest = push_dest_i;
                  ne.err  = push_err_i || ($countones(push_dest_i) != 1);
                  ne.len  = int'(push_len_i);
                  q.push_back(ne);
               end
            end
            @(posedge clk);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
